store_forward_buffer: RTL

Parametrised store-to-load forwarding buffer inserted between the execute stage and the data memory. It remembers the last stores whose memory writes have not yet become visible to reads, and merges their bytes into the read data of later loads to the same word. It replaces fixed-depth, word-only bypass logic with configurable depth, lifetime, width and byte-enable merging.

---
 rtl/mspu_fwd_pkg.sv | 28 ++
 rtl/store_fwd_entry.sv | 56 +++++
 rtl/store_forward_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mspu_fwd_pkg.sv
// Shared types and helpers for the store-to-load forwarding buffer.
// Default widths here match the top-level parameter defaults.
package mspu_fwd_pkg;

  localparam int FWD_ADDR_W   = 32;
  localparam int FWD_DATA_W   = 32;
  localparam int FWD_LIFETIME = 4;

  localparam int BYTES  = FWD_DATA_W / 8;
  localparam int IDX_LO = $clog2(BYTES);
  localparam int AGE_W  = $clog2(FWD_LIFETIME + 1);

  typedef struct packed {
    logic                         valid;
    logic [FWD_ADDR_W-IDX_LO-1:0] widx;
    logic [FWD_DATA_W-1:0]        data;
    logic [BYTES-1:0]             be;
    logic [AGE_W-1:0]             age;
  } fwd_entry_t;

  function automatic logic [63:0] word_idx(
    input logic [63:0] addr,
    input int          lo
  );
    return addr >> lo;
  endfunction

endpackage

// File: rtl/store_fwd_entry.sv
// One forwarding entry: stored word, byte enables and a lifetime counter.
// Age counts the remaining registered cycles in which the entry may forward.
module store_fwd_entry
  import mspu_fwd_pkg::*;
#(
  parameter  int WI_W     = 30,
  parameter  int DATA_W   = 32,
  parameter  int LIFETIME = 4,
  localparam int NB       = DATA_W / 8,
  localparam int AW       = $clog2(LIFETIME + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WI_W-1:0]   wr_widx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_be,
  input  logic [WI_W-1:0]   q_widx,
  output logic              valid,
  output logic [AW-1:0]     age,
  output logic [DATA_W-1:0] data,
  output logic [NB-1:0]     match
);

  logic [WI_W-1:0] widx;
  logic [NB-1:0]   be;

  // The issue cycle is served by bypass, so the entry holds LIFETIME-1 more.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (wr_en) begin
      valid <= (LIFETIME > 1);
      age   <= AW'(LIFETIME - 1);
    end else if (flush) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (valid) begin
      age <= age - 1'b1;
      if (age == AW'(1)) valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      widx <= wr_widx;
      data <= wr_data;
      be   <= wr_be;
    end
  end

  assign match = {NB{valid && (widx == q_widx)}} & be;

endmodule

// File: rtl/store_forward_buffer.sv
// Store-to-load forwarding buffer between execute and data memory.
// Merges youngest matching store bytes into the next-cycle load word.
module store_forward_buffer
  import mspu_fwd_pkg::*;
#(
  parameter  int ADDR_W   = FWD_ADDR_W,
  parameter  int DATA_W   = FWD_DATA_W,
  parameter  int DEPTH    = 4,
  parameter  int LIFETIME = FWD_LIFETIME,
  localparam int NB       = DATA_W / 8,
  localparam int OW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [NB-1:0]     st_be,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_data_valid,
  output logic              fwd_hit,
  output logic              fwd_full,
  output logic [OW-1:0]     occupancy,
  output logic              overflow
);

  localparam int LO   = $clog2(NB);
  localparam int WI_W = ADDR_W - LO;
  localparam int AW   = $clog2(LIFETIME + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WI_W-1:0]   st_widx;
  logic [WI_W-1:0]   ld_widx;
  logic [PW-1:0]     wr_ptr;
  logic [DEPTH-1:0]  e_valid;
  logic [AW-1:0]     e_age   [DEPTH];
  logic [DATA_W-1:0] e_data  [DEPTH];
  logic [NB-1:0]     e_match [DEPTH];

  assign st_widx = WI_W'(word_idx(64'(st_addr), LO));
  assign ld_widx = WI_W'(word_idx(64'(ld_addr), LO));

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    store_fwd_entry #(
      .WI_W    (WI_W),
      .DATA_W  (DATA_W),
      .LIFETIME(LIFETIME)
    ) u_ent (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .wr_en  (st_valid && (wr_ptr == PW'(i))),
      .wr_widx(st_widx),
      .wr_data(st_data),
      .wr_be  (st_be),
      .q_widx (ld_widx),
      .valid  (e_valid[i]),
      .age    (e_age[i]),
      .data   (e_data[i]),
      .match  (e_match[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (st_valid) begin
      wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (e_valid[wr_ptr]) overflow <= 1'b1;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++)
      occupancy = occupancy + OW'(e_valid[i]);
  end

  logic [DATA_W-1:0] fwd_d;
  logic [NB-1:0]     fwd_m;
  logic              found;
  logic [AW-1:0]     best;

  // Per lane: same-cycle store first, else the live entry with largest age.
  always_comb begin
    fwd_d = '0;
    fwd_m = '0;
    found = 1'b0;
    best  = '0;
    for (int b = 0; b < NB; b++) begin
      found = 1'b0;
      best  = '0;
      if (st_valid && st_be[b] && (st_widx == ld_widx)) begin
        fwd_d[b*8 +: 8] = st_data[b*8 +: 8];
        fwd_m[b]        = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (e_match[i][b] && (!found || (e_age[i] > best))) begin
            found           = 1'b1;
            best            = e_age[i];
            fwd_d[b*8 +: 8] = e_data[i][b*8 +: 8];
            fwd_m[b]        = 1'b1;
          end
        end
      end
    end
  end

  logic              pend;
  logic [DATA_W-1:0] fwd_q;
  logic [NB-1:0]     mask_q;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = '0;
    for (int b = 0; b < NB; b++)
      merged[b*8 +: 8] = mask_q[b] ? fwd_q[b*8 +: 8]
                                   : mem_rdata[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend   <= 1'b0;
      fwd_q  <= '0;
      mask_q <= '0;
      hold   <= '0;
    end else begin
      pend <= ld_valid;
      if (ld_valid) begin
        fwd_q  <= fwd_d;
        mask_q <= fwd_m;
      end
      if (pend) hold <= merged;
    end
  end

  assign ld_data       = pend ? merged : hold;
  assign ld_data_valid = pend;
  assign fwd_hit       = pend && (|mask_q);
  assign fwd_full      = pend && (&mask_q);

endmodule
